// File: rtl/sqrt_pipe_param.sv
// Pipelined unsigned fixed-point square root (restoring, MSB first) with
// valid/ready backpressure, sideband tag, optional round-to-nearest and exact flag.
module sqrt_pipe_param #(
   parameter int IN_W           = 32,
   parameter int FRAC_W         = 16,
   parameter int BITS_PER_STAGE = 2,
   parameter int TAG_W          = 4,
   parameter int ROUND          = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN_W-1:0]          in_data,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IN_W/2+FRAC_W-1:0] out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_exact
);

   localparam int OUT_W = IN_W/2 + FRAC_W;
   localparam int SW    = 2*OUT_W;
   localparam int RW    = OUT_W + 2;
   localparam int NSTG  = (OUT_W + BITS_PER_STAGE - 1) / BITS_PER_STAGE;

   if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_in_w
      $error("sqrt_pipe_param: IN_W must be even and >= 2");
   end
   if (BITS_PER_STAGE < 1 || BITS_PER_STAGE > 4) begin : g_bad_bps
      $error("sqrt_pipe_param: BITS_PER_STAGE must be in 1..4");
   end
   if (TAG_W < 1) begin : g_bad_tag_w
      $error("sqrt_pipe_param: TAG_W must be >= 1");
   end
   if (FRAC_W < 0) begin : g_bad_frac_w
      $error("sqrt_pipe_param: FRAC_W must be >= 0");
   end

   // One enable for the whole pipe: a stalled output freezes every stage, bubbles included.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Element gi feeds stage gi; element NSTG is the fully resolved root.
   logic             v_pipe [NSTG+1];
   logic [OUT_W-1:0] q_pipe [NSTG+1];
   logic [RW-1:0]    r_pipe [NSTG+1];
   logic [TAG_W-1:0] t_pipe [NSTG+1];
   logic [SW-1:0]    s_pipe [NSTG];

   assign v_pipe[0] = in_valid;
   assign q_pipe[0] = '0;
   assign r_pipe[0] = '0;
   assign t_pipe[0] = in_tag;
   assign s_pipe[0] = SW'(in_data) << (2*FRAC_W);

   genvar gi;
   generate
      for (gi = 0; gi < NSTG; gi++) begin : g_stg
         localparam int FIRST = OUT_W - 1 - gi*BITS_PER_STAGE;
         localparam int NB    = (FIRST + 1 < BITS_PER_STAGE) ? FIRST + 1 : BITS_PER_STAGE;

         logic [OUT_W-1:0] q_next;
         logic [RW-1:0]    r_next;
         logic [1:0]       pair;
         logic [RW-1:0]    r_shift;
         logic [RW-1:0]    trial;

         logic             valid_reg;
         logic [OUT_W-1:0] q_reg;
         logic [RW-1:0]    r_reg;
         logic [TAG_W-1:0] tag_reg;

         // Radix-2 restoring steps: bring down two radicand bits, try (q<<2)|1.
         always_comb begin
            q_next  = q_pipe[gi];
            r_next  = r_pipe[gi];
            pair    = '0;
            r_shift = '0;
            trial   = '0;
            for (int k = 0; k < NB; k++) begin
               pair    = s_pipe[gi][2*(FIRST-k) +: 2];
               r_shift = {r_next[RW-3:0], pair};
               trial   = {q_next, 2'b01};
               if (r_shift >= trial) begin
                  r_next = r_shift - trial;
                  q_next = (q_next << 1) | OUT_W'(1);
               end else begin
                  r_next = r_shift;
                  q_next = q_next << 1;
               end
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               valid_reg <= 1'b0;
            end else if (advance) begin
               valid_reg <= v_pipe[gi];
               if (v_pipe[gi]) begin
                  q_reg   <= q_next;
                  r_reg   <= r_next;
                  tag_reg <= t_pipe[gi];
               end
            end
         end

         assign v_pipe[gi+1] = valid_reg;
         assign q_pipe[gi+1] = q_reg;
         assign r_pipe[gi+1] = r_reg;
         assign t_pipe[gi+1] = tag_reg;

         if (gi < NSTG-1) begin : g_fwd
            logic [SW-1:0] s_reg;
            always_ff @(posedge clock) begin
               if (!reset && advance && v_pipe[gi]) begin
                  s_reg <= s_pipe[gi];
               end
            end
            assign s_pipe[gi+1] = s_reg;
         end
      end
   endgenerate

   logic             round_up;
   logic [OUT_W:0]   root_inc;
   logic [OUT_W-1:0] root_final;

   always_comb begin
      round_up   = (ROUND != 0) && (r_pipe[NSTG] > {2'b00, q_pipe[NSTG]});
      root_inc   = {1'b0, q_pipe[NSTG]} + {{OUT_W{1'b0}}, round_up};
      root_final = root_inc[OUT_W] ? '1 : root_inc[OUT_W-1:0];
   end

   // Output data only changes when a new result lands, so it stays put across bubbles.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_exact <= 1'b0;
      end else if (advance) begin
         out_valid <= v_pipe[NSTG];
         if (v_pipe[NSTG]) begin
            out_data  <= root_final;
            out_tag   <= t_pipe[NSTG];
            out_exact <= (r_pipe[NSTG] == '0);
         end
      end
   end

endmodule

// File: tb/tb_sqrt_pipe_param.sv
// Directed-vector and streaming bench for sqrt_pipe_param across four configurations.
module tb_sqrt_pipe_param;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset;

   // Default config pair (truncating / rounding), driven with identical stimulus.
   logic        d_in_valid, d_out_ready;
   logic [31:0] d_in_data;
   logic [3:0]  d_in_tag;
   logic        t_in_ready, t_out_valid, t_out_exact;
   logic [31:0] t_out_data;
   logic [3:0]  t_out_tag;
   logic        r_in_ready, r_out_valid, r_out_exact;
   logic [31:0] r_out_data;
   logic [3:0]  r_out_tag;
   // IN_W=16, FRAC_W=8, BITS_PER_STAGE=3
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_exact;
   logic [15:0] a_in_data, a_out_data;
   logic [3:0]  a_in_tag, a_out_tag;
   // IN_W=8, FRAC_W=0, BITS_PER_STAGE=1
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_exact;
   logic [7:0]  b_in_data;
   logic [3:0]  b_out_data, b_in_tag, b_out_tag;

   sqrt_pipe_param dut_t (
      .clock(clock), .reset(reset), .in_valid(d_in_valid), .in_ready(t_in_ready),
      .in_data(d_in_data), .in_tag(d_in_tag), .out_valid(t_out_valid), .out_ready(d_out_ready),
      .out_data(t_out_data), .out_tag(t_out_tag), .out_exact(t_out_exact));

   sqrt_pipe_param #(.ROUND(1)) dut_r (
      .clock(clock), .reset(reset), .in_valid(d_in_valid), .in_ready(r_in_ready),
      .in_data(d_in_data), .in_tag(d_in_tag), .out_valid(r_out_valid), .out_ready(d_out_ready),
      .out_data(r_out_data), .out_tag(r_out_tag), .out_exact(r_out_exact));

   sqrt_pipe_param #(.IN_W(16), .FRAC_W(8), .BITS_PER_STAGE(3)) dut_a (
      .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(1'b1),
      .out_data(a_out_data), .out_tag(a_out_tag), .out_exact(a_out_exact));

   sqrt_pipe_param #(.IN_W(8), .FRAC_W(0), .BITS_PER_STAGE(1)) dut_b (
      .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(1'b1),
      .out_data(b_out_data), .out_tag(b_out_tag), .out_exact(b_out_exact));

   int tests = 0;
   int fails = 0;

   int          cur = 0;
   logic        sel_valid, sel_exact;
   logic [31:0] sel_data;
   logic [3:0]  sel_tag;

   always_comb begin
      sel_valid = t_out_valid;
      sel_data  = t_out_data;
      sel_tag   = t_out_tag;
      sel_exact = t_out_exact;
      case (cur)
         1: begin sel_valid = r_out_valid; sel_data = r_out_data;        sel_tag = r_out_tag; sel_exact = r_out_exact; end
         2: begin sel_valid = a_out_valid; sel_data = 32'(a_out_data);   sel_tag = a_out_tag; sel_exact = a_out_exact; end
         3: begin sel_valid = b_out_valid; sel_data = 32'(b_out_data);   sel_tag = b_out_tag; sel_exact = b_out_exact; end
         default: ;
      endcase
   end

   typedef struct {
      int          dut;
      logic [31:0] x;
      logic [3:0]  tag;
      logic [31:0] exp_data;
      logic        exp_exact;
      int          lat;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] trunc;
      logic [32:0] rnd;
      logic        exact;
      logic [3:0]  tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int dut, input logic [31:0] x, input logic [3:0] tag, input logic v);
      if (dut <= 1) begin
         d_in_valid = v; d_in_data = x; d_in_tag = tag;
      end else if (dut == 2) begin
         a_in_valid = v; a_in_data = x[15:0]; a_in_tag = tag;
      end else begin
         b_in_valid = v; b_in_data = x[7:0]; b_in_tag = tag;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int cyc;
      cur = v.dut;
      @(posedge clock); #1;
      drive(v.dut, v.x, v.tag, 1'b1);
      @(posedge clock); #1;
      drive(v.dut, 32'h0, 4'h0, 1'b0);
      cyc = 0;
      while (!sel_valid && cyc < 64) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk({v.name, ".latency"}, 64'(cyc), 64'(v.lat));
      chk({v.name, ".data"}, 64'(sel_data), 64'(v.exp_data));
      chk({v.name, ".tag"}, 64'(sel_tag), 64'(v.tag));
      chk({v.name, ".exact"}, 64'(sel_exact), 64'(v.exp_exact));
      $display("[TB] %s dut%0d x=0x%0h -> data=0x%0h tag=%0d exact=%0b after %0d cycles",
               v.name, v.dut, v.x, sel_data, sel_tag, sel_exact, cyc);
   endtask

   // Reference root for the default config by bitwise search on R*R <= X*2^32.
   function automatic exp_t ref_sqrt(input logic [31:0] x, input logic [3:0] tag);
      exp_t        e;
      logic [63:0] s, r, c, rem;
      s = {x, 32'h0};
      r = 64'h0;
      for (int b = 31; b >= 0; b--) begin
         c = r | (64'd1 << b);
         if (c * c <= s) r = c;
      end
      rem     = s - r * r;
      e.trunc = r[31:0];
      e.exact = (rem == 64'h0);
      e.rnd   = {1'b0, r[31:0]} + ((rem > r) ? 33'd1 : 33'd0);
      e.tag   = tag;
      return e;
   endfunction

   initial begin
      int          sent, got, cyc, stale;
      logic        stalled;
      logic [31:0] h_t, h_r;
      logic [3:0]  h_tag;
      logic        h_ex;
      exp_t        e;

      vecs.push_back('{0, 32'd4,          4'd3, 32'h0002_0000, 1'b1, 16, "def_x4"});
      vecs.push_back('{0, 32'd2,          4'd5, 32'h0001_6A09, 1'b0, 16, "def_x2"});
      vecs.push_back('{0, 32'd0,          4'd1, 32'h0000_0000, 1'b1, 16, "def_x0"});
      vecs.push_back('{0, 32'hFFFF_FFFF,  4'd9, 32'hFFFF_FFFF, 1'b0, 16, "def_xmax"});
      vecs.push_back('{0, 32'd3,          4'd2, 32'h0001_BB67, 1'b0, 16, "def_x3"});
      vecs.push_back('{0, 32'd5,          4'd7, 32'h0002_3C6E, 1'b0, 16, "def_x5"});
      vecs.push_back('{0, 32'h0001_0000,  4'd4, 32'h0100_0000, 1'b1, 16, "def_x65536"});
      vecs.push_back('{0, 32'd1,          4'hF, 32'h0001_0000, 1'b1, 16, "def_x1"});
      vecs.push_back('{1, 32'd2,          4'd5, 32'h0001_6A0A, 1'b0, 16, "rnd_x2"});
      vecs.push_back('{1, 32'hFFFF_FFFF,  4'd6, 32'hFFFF_FFFF, 1'b0, 16, "rnd_xmax"});
      vecs.push_back('{1, 32'd3,          4'd8, 32'h0001_BB68, 1'b0, 16, "rnd_x3"});
      vecs.push_back('{1, 32'd5,          4'd0, 32'h0002_3C6F, 1'b0, 16, "rnd_x5"});
      vecs.push_back('{1, 32'd4,          4'd3, 32'h0002_0000, 1'b1, 16, "rnd_x4"});
      vecs.push_back('{2, 32'd2,          4'd1, 32'h0000_016A, 1'b0, 6,  "a_x2"});
      vecs.push_back('{2, 32'd9,          4'd2, 32'h0000_0300, 1'b1, 6,  "a_x9"});
      vecs.push_back('{2, 32'h0000_FFFF,  4'd3, 32'h0000_FFFF, 1'b0, 6,  "a_xmax"});
      vecs.push_back('{3, 32'd200,        4'd4, 32'd14,        1'b0, 4,  "b_x200"});
      vecs.push_back('{3, 32'd196,        4'd5, 32'd14,        1'b1, 4,  "b_x196"});
      vecs.push_back('{3, 32'd255,        4'd6, 32'd15,        1'b0, 4,  "b_x255"});
      vecs.push_back('{3, 32'd0,          4'd7, 32'd0,         1'b1, 4,  "b_x0"});

      reset = 1'b1;
      d_in_valid = 1'b0; d_in_data = '0; d_in_tag = '0; d_out_ready = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("reset.out_valid", 64'(t_out_valid), 64'd0);
      chk("reset.out_data", 64'(t_out_data), 64'd0);
      chk("reset.out_tag", 64'(t_out_tag), 64'd0);
      chk("reset.out_exact", 64'(t_out_exact), 64'd0);
      chk("reset.in_ready", 64'(t_in_ready), 64'd1);
      chk("reset.alt_valid", 64'({a_out_valid, b_out_valid, r_out_valid}), 64'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Streaming with random backpressure, checked in order against the model.
      cur = 0;
      sent = 0; got = 0; cyc = 0; stalled = 1'b0;
      h_t = '0; h_r = '0; h_tag = '0; h_ex = 1'b0;
      @(posedge clock); #1;
      while (got < 100 && cyc < 3000) begin
         d_out_ready = ($urandom_range(0, 99) >= 30);
         if (sent < 100) begin
            d_in_valid = 1'b1;
            d_in_data  = (sent % 10 == 0) ? 32'h0 : (sent % 10 == 5) ? 32'hFFFF_FFFF : 32'($urandom);
            d_in_tag   = 4'(sent);
         end else begin
            d_in_valid = 1'b0;
         end
         #1;
         if (stalled) begin
            chk("stall.valid", 64'(t_out_valid), 64'd1);
            chk("stall.data", 64'(t_out_data), 64'(h_t));
            chk("stall.rdata", 64'(r_out_data), 64'(h_r));
            chk("stall.tag", 64'(t_out_tag), 64'(h_tag));
            chk("stall.exact", 64'(t_out_exact), 64'(h_ex));
         end
         chk("stream.in_ready", 64'(t_in_ready), 64'(!(t_out_valid && !d_out_ready)));
         if (t_out_valid && d_out_ready) begin
            if (sb.size() == 0) begin
               chk("stream.unexpected_result", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("stream.data", 64'(t_out_data), 64'(e.trunc));
               chk("stream.rdata", 64'(r_out_data), 64'(e.rnd));
               chk("stream.tag", 64'(t_out_tag), 64'(e.tag));
               chk("stream.rtag", 64'(r_out_tag), 64'(e.tag));
               chk("stream.exact", 64'(t_out_exact), 64'(e.exact));
               $display("[TB] stream #%0d tag=%0d data=0x%0h rdata=0x%0h exact=%0b",
                        got, t_out_tag, t_out_data, r_out_data, t_out_exact);
            end
            got++;
         end
         stalled = t_out_valid && !d_out_ready;
         h_t = t_out_data; h_r = r_out_data; h_tag = t_out_tag; h_ex = t_out_exact;
         if (d_in_valid && t_in_ready) begin
            sb.push_back(ref_sqrt(d_in_data, d_in_tag));
            sent++;
         end
         @(posedge clock); #1;
         cyc++;
      end
      chk("stream.count", 64'(got), 64'd100);
      d_in_valid = 1'b0;
      d_out_ready = 1'b1;

      // Reset with ten operands in flight and a transfer offered on the reset edge.
      repeat (20) @(posedge clock);
      #1;
      for (int i = 0; i < 10; i++) begin
         d_in_valid = 1'b1; d_in_data = 32'(i + 1); d_in_tag = 4'(i);
         @(posedge clock); #1;
      end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      d_in_valid = 1'b0;
      chk("midreset.out_valid", 64'(t_out_valid), 64'd0);
      chk("midreset.out_data", 64'(t_out_data), 64'd0);
      chk("midreset.out_tag", 64'(t_out_tag), 64'd0);
      chk("midreset.out_exact", 64'(t_out_exact), 64'd0);
      chk("midreset.in_ready", 64'(t_in_ready), 64'd1);
      stale = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         if (t_out_valid || r_out_valid) stale++;
      end
      chk("midreset.stale", 64'(stale), 64'd0);
      $display("[TB] mid-flight reset: %0d stale results observed", stale);
      run_vec('{0, 32'd9, 4'd9, 32'h0003_0000, 1'b1, 16, "post_reset_x9"});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sqrt_pipe_param.md
Name: sqrt_pipe_param

Overview:
- Parametrised, fully pipelined unsigned fixed-point square-root unit. Successor to the fixed 32-bit/16.16 root pipeline.
- Adds configurable input width, fractional precision and bits-per-stage.
- Adds valid/ready backpressure, a pass-through tag for out-of-band context, optional round-to-nearest, and an exactness flag.
- Sits after the sum-of-squares accumulator in the magnitude datapath. Accepts one operand per cycle.

Parameters:
- IN_W, 32, input operand width (unsigned integer); must be even, >= 2.
- FRAC_W, 16, fractional bits in the result; >= 0.
- BITS_PER_STAGE, 2, root bits resolved per pipeline stage; 1..4.
- TAG_W, 4, width of the sideband tag carried alongside each operand; >= 1.
- ROUND, 0, 0 = truncate (floor); 1 = round to nearest, ties up.
- Derived: OUT_W = IN_W/2 + FRAC_W; NSTG = ceil(OUT_W / BITS_PER_STAGE).

Ports:
- clock      in   1       clock
- reset      in   1       synchronous, active-high reset
- in_valid   in   1       operand present
- in_ready   out  1       unit can accept an operand this cycle
- in_data    in   IN_W    unsigned operand X
- in_tag     in   TAG_W   sideband tag, returned unmodified with the result
- out_valid  out  1       result present
- out_ready  in   1       downstream accepts the result
- out_data   out  OUT_W   root, fixed point U(IN_W/2).FRAC_W
- out_tag    out  TAG_W   tag of the operand that produced out_data
- out_exact  out  1       1 when the remainder is zero (the root is exact)

Behaviour:
- Interface: clock is clock; reset is reset, synchronous, active-high.
- Function:
  - S = X * 2^(2*FRAC_W), computed at IN_W + 2*FRAC_W bits.
  - R = floor(sqrt(S)); rem = S - R^2.
  - out_exact = (rem == 0).
  - ROUND=1: out_data = R + (rem > R ? 1 : 0); otherwise out_data = R.
  - The round increment never carries out of OUT_W. Implementation still saturates at all-ones; the bench asserts this saturation is never reached.
- Algorithm: restoring digit-by-digit, MSB first. Each stage resolves BITS_PER_STAGE root bits. A non-integer final group resolves only the remaining bits. Each stage carries partial root, partial remainder, tag and valid. No multipliers wider than the stage's working width.
- Handshake:
  - Transfer occurs on an edge where valid && ready.
  - in_ready = !out_valid || out_ready. Global enable: when out_valid && !out_ready, every stage holds, including bubbles.
  - While stalled, out_data, out_tag and out_exact are stable.
  - in_data and in_tag are sampled only on a transfer.
- Latency: an operand accepted on edge k, with no stalls, gives out_valid=1 after edge k+NSTG. Default NSTG = 16.
- Throughput: 1 result/cycle while out_ready=1.
- Order: results leave strictly in acceptance order. Tags are never reordered or altered.
- Reset:
  - All stage valids clear.
  - out_valid=0, out_data=0, out_tag=0, out_exact=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight operands; no partial result is emitted.
  - Reset dominates a simultaneous transfer.
- Simultaneous events: with a full pipe and out_ready=1, an input transfer and an output transfer happen on the same edge.
- Zero input: X=0 gives out_data=0, out_exact=1.
- Data in invalid stages is don't-care internally. out_data, out_tag and out_exact are still held stable whenever out_valid=0 after the last result, to ease waveform debug.
- Elaboration fails (static assertion) if IN_W is odd, BITS_PER_STAGE is outside 1..4, or TAG_W < 1.

Test Plan:
- Defaults; X=4, tag=3 -> exactly 16 cycles after accept: out_data=0x00020000, out_tag=3, out_exact=1.
- Defaults; X=2 -> out_data=0x00016A09, out_exact=0. Same with ROUND=1 -> 0x00016A0A.
- Defaults; X=0 -> 0x00000000, exact=1. X=0xFFFFFFFF -> 0xFFFFFFFF, exact=0, also with ROUND=1 (no overflow).
- Stream 100 random operands back-to-back; random out_ready with ~30% stall -> results match the reference model in order with tags intact; in_ready=0 exactly when out_valid && !out_ready; outputs stable during stalls.
- Assert reset with 10 operands in flight -> out_valid=0 next cycle, no stale result appears afterwards; a new X=9 gives 0x00030000 after 16 cycles.
- Alternate configs: IN_W=16, FRAC_W=8, BITS_PER_STAGE=3 (OUT_W=16, NSTG=6); X=2 -> 0x016A, latency 6. IN_W=8, FRAC_W=0, BITS_PER_STAGE=1; X=200 -> 14, exact=0.
